dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer for the single-port data memory (1-cycle registered read).
//  Port A serves the CPU load/store stage; port B serves a DMA/debug master.
//  Captures one request at a time, drives the memory cs/rd/wr/addr/wdata strobes and returns a done pulse with read data.
//  One transaction every 3 cycles.
// PARAMETERS
//  AW        32    address width of requester and memory address ports
//  DW        32    data width
//  DEPTH     1024  memory words; valid addresses 0..DEPTH-1
//  ARB_MODE  0     0 = round-robin between A and B; 1 = fixed priority, A wins
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst        in   1   asynchronous reset, active-high
//  a_req      in   1   A request valid; hold until a_gnt is seen
//  a_we       in   1   A op: 1 = write, 0 = read
//  a_addr     in   AW  A word address
//  a_wdata    in   DW  A write data
//  a_gnt      out  1   1-cycle pulse: A request captured
//  a_done     out  1   1-cycle pulse: A op complete, a_rdata valid for reads
//  a_rdata    out  DW  A read data, held until next A read completes
//  a_err      out  1   A address error, valid with a_done (feature-dependent)
//  b_*        -    -   same set as a_* for requester B
//  mem_cs     out  1   memory chip select
//  mem_rd     out  1   memory read strobe
//  mem_wr     out  1   memory write strobe
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data, registered by memory on the edge after issue
// BEHAVIOUR
//  Reset values (async, immediate): state=IDLE; all outputs 0; last_grant=B so A wins the first tie.
//  FSM: IDLE -> ISSUE -> RESP -> IDLE.
//  - IDLE at edge E0, any req=1: pick winner.
//    - Latch we/addr/wdata into mem_* regs.
//    - mem_cs<=1; mem_rd<=!we; mem_wr<=we.
//    - x_gnt<=1; state<=ISSUE.
//  - ISSUE at edge E1: memory performs the op. mem_cs/rd/wr<=0; gnt<=0; state<=RESP.
//  - RESP at edge E2: x_done<=1, x_err per feature; state<=IDLE.
//    - Reads: x_rdata<=mem_rdata.
//    - Writes: x_rdata unchanged.
//  - done is high in the IDLE cycle after E2, 0 on the next edge.
//  - Next grant possible at E3. Req-to-done latency: 3 edges.
//  Requester rules:
//  - Deassert req in the cycle gnt is high, or present new fields for a back-to-back op.
//  - req is only sampled in IDLE.
//  Arbitration:
//  - ARB_MODE=0: both req -> grant the one not in last_grant; last_grant updates on every grant.
//  - ARB_MODE=1: A always wins a tie; B can starve.
//  - Single requester is always granted.
//  Invariants:
//  - mem_rd and mem_wr never both 1; neither is 1 without mem_cs.
//  - mem_cs is high exactly one cycle per transaction.
//  - gnt and done pulses are one-hot across A/B.
//  Width: addr passed through unmodified; the memory decodes the low bits.
//  Reset mid-operation:
//  - Outputs clear at once; the in-flight op is dropped, no done.
//  - Reset during ISSUE: mem_cs already 0 at E1, so no write is committed.
//  - Writes committed at an edge before reset remain.
// CONFIGURATION
//  DMEM_ARB_RANGE_CHECK_EN defined:
//  - Latched addr >= DEPTH: ISSUE keeps mem_cs/rd/wr=0, no memory access.
//  - RESP still fires done, with x_err=1 and x_rdata<=0 (read or write).
//  - In-range ops have x_err=0.
//  DMEM_ARB_RANGE_CHECK_EN undefined:
//  - No check; all addresses reach the memory.
//  - a_err/b_err tied 0.
//  Timing is identical in both builds.
// TESTING
//  1. A write addr 5 data 0xDEADBEEF, then A read addr 5:
//     a_gnt at E0+1, mem_wr one cycle, a_done 3 edges after req; a_rdata=0xDEADBEEF.
//  2. B read addr 17 on fresh (initialised) memory: b_done with b_rdata=17 (init value = index); a_* stay 0.
//  3. A and B req held high with reads, ARB_MODE=0:
//     grants A,B,A,B; done pulses 3 cycles apart.
//     ARB_MODE=1: A,A,A with no b_gnt.
//  4. A write addr 9 data 0x55, rst pulsed during ISSUE:
//     all outputs 0 same cycle, no a_done; later read of 9 returns 9.
//  5. Macro on, A read addr 1024: mem_cs never 1; a_done with a_err=1, a_rdata=0.
//     Macro off: mem_cs pulses, a_err=0.
//  6. Protocol monitor throughout: mem_rd&mem_wr never 1; mem_cs width 1; a_gnt&b_gnt never 1.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester port bundle for the data memory arbiter
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          done;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (output req, we, addr, wdata, input gnt, done, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, done, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester sequencer for a single-port 1-cycle-read data memory
// Optional address range check: DMEM_ARB_RANGE_CHECK_EN
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 1024,
    parameter int ARB_MODE = 0
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  a,
    dmem_arbiter_if.slave  b,
    output logic           mem_cs,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata
);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state, state_n;
    logic          last_b, last_b_n;
    logic          cur_b, cur_b_n;
    logic          cur_we, cur_we_n;
    logic          cur_bad, cur_bad_n;
    logic          cs_n, rd_n, wr_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] wdata_n;
    logic          a_gnt_q, a_gnt_n, b_gnt_q, b_gnt_n;
    logic          a_done_q, a_done_n, b_done_q, b_done_n;
    logic          a_err_q, a_err_n, b_err_q, b_err_n;
    logic [DW-1:0] a_rdata_q, a_rdata_n, b_rdata_q, b_rdata_n;

    logic          pick_b, win_we, win_bad;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    always_comb begin
        // B wins only if A is idle, or on a round-robin tie when A went last
        pick_b    = b.req & (~a.req | ((ARB_MODE == 0) & ~last_b));
        win_we    = pick_b ? b.we    : a.we;
        win_addr  = pick_b ? b.addr  : a.addr;
        win_wdata = pick_b ? b.wdata : a.wdata;
        win_bad   = RANGE_CHK && (win_addr >= AW'(DEPTH));
    end

    always_comb begin
        state_n   = state;
        last_b_n  = last_b;
        cur_b_n   = cur_b;
        cur_we_n  = cur_we;
        cur_bad_n = cur_bad;
        cs_n      = mem_cs;
        rd_n      = mem_rd;
        wr_n      = mem_wr;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        a_gnt_n   = 1'b0;
        b_gnt_n   = 1'b0;
        a_done_n  = 1'b0;
        b_done_n  = 1'b0;
        a_err_n   = 1'b0;
        b_err_n   = 1'b0;
        a_rdata_n = a_rdata_q;
        b_rdata_n = b_rdata_q;
        case (state)
            IDLE: begin
                if (a.req | b.req) begin
                    addr_n    = win_addr;
                    wdata_n   = win_wdata;
                    cs_n      = ~win_bad;
                    rd_n      = ~win_bad & ~win_we;
                    wr_n      = ~win_bad & win_we;
                    a_gnt_n   = ~pick_b;
                    b_gnt_n   = pick_b;
                    last_b_n  = pick_b;
                    cur_b_n   = pick_b;
                    cur_we_n  = win_we;
                    cur_bad_n = win_bad;
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                cs_n    = 1'b0;
                rd_n    = 1'b0;
                wr_n    = 1'b0;
                state_n = RESP;
            end
            RESP: begin
                if (cur_b) begin
                    b_done_n = 1'b1;
                    b_err_n  = cur_bad;
                    if (cur_bad)      b_rdata_n = '0;
                    else if (!cur_we) b_rdata_n = mem_rdata;
                end else begin
                    a_done_n = 1'b1;
                    a_err_n  = cur_bad;
                    if (cur_bad)      a_rdata_n = '0;
                    else if (!cur_we) a_rdata_n = mem_rdata;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            cur_b     <= 1'b0;
            cur_we    <= 1'b0;
            cur_bad   <= 1'b0;
            mem_cs    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            a_gnt_q   <= 1'b0;
            b_gnt_q   <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state     <= state_n;
            last_b    <= last_b_n;
            cur_b     <= cur_b_n;
            cur_we    <= cur_we_n;
            cur_bad   <= cur_bad_n;
            mem_cs    <= cs_n;
            mem_rd    <= rd_n;
            mem_wr    <= wr_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            a_gnt_q   <= a_gnt_n;
            b_gnt_q   <= b_gnt_n;
            a_done_q  <= a_done_n;
            b_done_q  <= b_done_n;
            a_err_q   <= a_err_n;
            b_err_q   <= b_err_n;
            a_rdata_q <= a_rdata_n;
            b_rdata_q <= b_rdata_n;
        end
    end

    assign a.gnt   = a_gnt_q;
    assign b.gnt   = b_gnt_q;
    assign a.done  = a_done_q;
    assign b.done  = b_done_q;
    assign a.err   = a_err_q;
    assign b.err   = b_err_q;
    assign a.rdata = a_rdata_q;
    assign b.rdata = b_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter, round-robin and fixed-priority instances
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    dmem_arbiter_if #(.AW(32), .DW(32)) a0 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) b0 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) a1 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) b1 ();

    logic        m0_cs, m0_rd, m0_wr, m1_cs, m1_rd, m1_wr;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];

    dmem_arbiter #(.AW(32), .DW(32), .DEPTH(1024), .ARB_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .a(a0), .b(b0),
        .mem_cs(m0_cs), .mem_rd(m0_rd), .mem_wr(m0_wr),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_rdata(m0_rdata)
    );

    dmem_arbiter #(.AW(32), .DW(32), .DEPTH(1024), .ARB_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
        .mem_cs(m1_cs), .mem_rd(m1_rd), .mem_wr(m1_wr),
        .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem0[i] = 32'(i);
            mem1[i] = 32'(i);
        end
    end

    always @(posedge clk) begin
        if (m0_cs) begin
            if (m0_wr) mem0[m0_addr[9:0]] <= m0_wdata;
            if (m0_rd) m0_rdata <= mem0[m0_addr[9:0]];
        end
        if (m1_cs) begin
            if (m1_wr) mem1[m1_addr[9:0]] <= m1_wdata;
            if (m1_rd) m1_rdata <= mem1[m1_addr[9:0]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic prev0 = 1'b0;
    logic prev1 = 1'b0;
    always @(negedge clk) begin
        chk("mon0_rd_wr", 64'(m0_rd & m0_wr), 64'd0);
        chk("mon0_strobe_no_cs", 64'((m0_rd | m0_wr) & ~m0_cs), 64'd0);
        chk("mon0_cs_width", 64'(m0_cs & prev0), 64'd0);
        chk("mon0_gnt_onehot", 64'(a0.gnt & b0.gnt), 64'd0);
        chk("mon0_done_onehot", 64'(a0.done & b0.done), 64'd0);
        chk("mon1_rd_wr", 64'(m1_rd & m1_wr), 64'd0);
        chk("mon1_cs_width", 64'(m1_cs & prev1), 64'd0);
        chk("mon1_gnt_onehot", 64'(a1.gnt & b1.gnt), 64'd0);
        prev0 = m0_cs;
        prev1 = m1_cs;
    end

    task automatic run_op(input string tag, input bit sel_b, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err,
                          input bit exp_cs);
        if (sel_b) begin
            b0.req = 1'b1; b0.we = we; b0.addr = addr; b0.wdata = wdata;
        end else begin
            a0.req = 1'b1; a0.we = we; a0.addr = addr; a0.wdata = wdata;
        end
        @(negedge clk);
        chk({tag, "_gnt"}, 64'(sel_b ? b0.gnt : a0.gnt), 64'd1);
        chk({tag, "_other_gnt"}, 64'(sel_b ? a0.gnt : b0.gnt), 64'd0);
        chk({tag, "_cs"}, 64'(m0_cs), 64'(exp_cs));
        chk({tag, "_rd"}, 64'(m0_rd), 64'(exp_cs & ~we));
        chk({tag, "_wr"}, 64'(m0_wr), 64'(exp_cs & we));
        chk({tag, "_addr"}, 64'(m0_addr), 64'(addr));
        a0.req = 1'b0;
        b0.req = 1'b0;
        @(negedge clk);
        chk({tag, "_cs_off"}, 64'(m0_cs), 64'd0);
        chk({tag, "_early_done"}, 64'(sel_b ? b0.done : a0.done), 64'd0);
        @(negedge clk);
        chk({tag, "_done"}, 64'(sel_b ? b0.done : a0.done), 64'd1);
        chk({tag, "_other_done"}, 64'(sel_b ? a0.done : b0.done), 64'd0);
        chk({tag, "_err"}, 64'(sel_b ? b0.err : a0.err), 64'(exp_err));
        chk({tag, "_rdata"}, 64'(sel_b ? b0.rdata : a0.rdata), 64'(exp_rd));
    endtask

    initial begin
        rst = 1'b1;
        a0.req = 0; a0.we = 0; a0.addr = 0; a0.wdata = 0;
        b0.req = 0; b0.we = 0; b0.addr = 0; b0.wdata = 0;
        a1.req = 0; a1.we = 0; a1.addr = 0; a1.wdata = 0;
        b1.req = 0; b1.we = 0; b1.addr = 0; b1.wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_a_gnt", 64'(a0.gnt), 64'd0);
        chk("rst_a_done", 64'(a0.done), 64'd0);
        chk("rst_b_rdata", 64'(b0.rdata), 64'd0);
        chk("rst_mem_cs", 64'(m0_cs), 64'd0);
        chk("rst_mem_addr", 64'(m0_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // write then read back through port A
        run_op("t1_wr", 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1);
        run_op("t1_rd", 1'b0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);

        run_op("t2_b_rd", 1'b1, 1'b0, 32'd17, 32'd0, 32'd17, 1'b0, 1'b1);
        chk("t2_a_rdata_kept", 64'(a0.rdata), 64'hDEADBEEF);

        // both requesters held: dut0 alternates, dut1 always picks A
        a0.req = 1; a0.we = 0; a0.addr = 32'd2;
        b0.req = 1; b0.we = 0; b0.addr = 32'd3;
        a1.req = 1; a1.we = 0; a1.addr = 32'd2;
        b1.req = 1; b1.we = 0; b1.addr = 32'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_rr_a_gnt", 64'(a0.gnt), 64'(k % 2 == 0));
            chk("t3_rr_b_gnt", 64'(b0.gnt), 64'(k % 2 == 1));
            chk("t3_fp_a_gnt", 64'(a1.gnt), 64'd1);
            chk("t3_fp_b_gnt", 64'(b1.gnt), 64'd0);
            repeat (2) @(negedge clk);
            chk("t3_rr_a_done", 64'(a0.done), 64'(k % 2 == 0));
            chk("t3_rr_b_done", 64'(b0.done), 64'(k % 2 == 1));
            chk("t3_rr_rdata", 64'((k % 2 == 1) ? b0.rdata : a0.rdata), (k % 2 == 1) ? 64'd3 : 64'd2);
            chk("t3_fp_a_done", 64'(a1.done), 64'd1);
            chk("t3_fp_a_rdata", 64'(a1.rdata), 64'd2);
            chk("t3_fp_b_done", 64'(b1.done), 64'd0);
        end
        a0.req = 0; b0.req = 0; a1.req = 0; b1.req = 0;
        @(negedge clk);

        // reset while the write sits in ISSUE: nothing committed
        a0.req = 1; a0.we = 1; a0.addr = 32'd9; a0.wdata = 32'h55;
        @(negedge clk);
        chk("t4_gnt", 64'(a0.gnt), 64'd1);
        a0.req = 0;
        rst = 1'b1;
        #1;
        chk("t4_rst_gnt", 64'(a0.gnt), 64'd0);
        chk("t4_rst_cs", 64'(m0_cs), 64'd0);
        chk("t4_rst_wr", 64'(m0_wr), 64'd0);
        chk("t4_rst_rdata", 64'(a0.rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_no_done", 64'(a0.done), 64'd0);
        end
        run_op("t4_rd9", 1'b0, 1'b0, 32'd9, 32'd0, 32'd9, 1'b0, 1'b1);

`ifdef DMEM_ARB_RANGE_CHECK_EN
        run_op("t5_oor", 1'b0, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b1, 1'b0);
`else
        run_op("t5_oor", 1'b0, 1'b0, 32'd1024, 32'd0, 32'd0, 1'b0, 1'b1);
`endif
        run_op("t5_inrange", 1'b1, 1'b0, 32'd1023, 32'd0, 32'd1023, 1'b0, 1'b1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
